bsg_fifo_1r1w_sync_read: RTL and testbench

Storage and handshake stage for a 1-read/1-write FIFO whose pointers come from an external `bsg_fifo_tracker`. The block sits directly beside the tracker. It turns valid/ready traffic into the tracker's `enq_i`/`deq_i`. It writes the array at the tracker's write pointer and reads a synchronous-read array at the tracker's `rptr_n_o`, so head data is registered and present at `data_o`. It also owns reset sequencing for the tracker.

---
 rtl/bsg_fifo_pkg.sv | 9 +
 rtl/bsg_mem_1r1w_sync.sv | 23 ++
 rtl/bsg_fifo_1r1w_sync_read.sv | 71 +++++++
 tb/tb_bsg_fifo_1r1w_sync_read.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_pkg.sv
// bsg_fifo_pkg: pointer-width helper and pointer type shared by the FIFO storage and tracker wrapper
package bsg_fifo_pkg;
  localparam int bsg_fifo_els_default = 256;
  function automatic int bsg_fifo_lg(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction
  localparam int bsg_fifo_lg_default = bsg_fifo_lg(bsg_fifo_els_default);
  typedef logic [bsg_fifo_lg_default-1:0] bsg_fifo_ptr_t;
endpackage

// File: rtl/bsg_mem_1r1w_sync.sv
// bsg_mem_1r1w_sync: unreset 1-write/1-read array with a registered read port
module bsg_mem_1r1w_sync
  import bsg_fifo_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 256,
  localparam int addr_w_lp = bsg_fifo_lg(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);
  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;
  always_ff @(posedge clk_i) begin
    if (w_v_i) r_mem[w_addr_i] <= w_data_i;
    r_data <= r_mem[r_addr_i];
  end
  assign r_data_o = r_data;
endmodule

// File: rtl/bsg_fifo_1r1w_sync_read.sv
// bsg_fifo_1r1w_sync_read: registered-head FIFO storage beside a bsg_fifo_tracker; BSG_FIFO_1R1W_COUNT_EN adds count_o
module bsg_fifo_1r1w_sync_read
  import bsg_fifo_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p = 256,
  localparam int lg_els_lp = bsg_fifo_lg(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,
  output logic                 tracker_reset_o,
  output logic                 enq_o,
  output logic                 deq_o,
  input  logic [lg_els_lp-1:0] wptr_r_i,
  input  logic [lg_els_lp-1:0] rptr_n_i,
  input  logic                 full_i,
  input  logic                 empty_i
`ifdef BSG_FIFO_1R1W_COUNT_EN
  ,
  output logic [lg_els_lp:0]   count_o
`endif
);
  logic r_init, r_sel_byp, w_byp;
  logic [width_p-1:0] r_byp_data, w_mem_data;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_init <= 1'b0;
    else r_init <= 1'b1;
  always_comb begin
    tracker_reset_o = ~r_init;
    ready_o = r_init & ~full_i;
    v_o = r_init & ~empty_i;
    enq_o = v_i & ready_o;
    deq_o = yumi_i & v_o;
    w_byp = enq_o & (wptr_r_i == rptr_n_i);
    data_o = r_sel_byp ? r_byp_data : w_mem_data;
  end
  // The array read register has no reset, so the head register is split: selecting the
  // bypass copy (reset to 0) during reset gives data_o=0 without resetting the array.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_sel_byp <= 1'b1;
      r_byp_data <= '0;
    end else begin
      r_sel_byp <= w_byp;
      if (w_byp) r_byp_data <= data_i;
    end
  bsg_mem_1r1w_sync #(.width_p(width_p), .els_p(els_p)) u_mem (
    .clk_i(clk_i),
    .w_v_i(enq_o),
    .w_addr_i(wptr_r_i),
    .w_data_i(data_i),
    .r_addr_i(rptr_n_i),
    .r_data_o(w_mem_data)
  );
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`ifdef BSG_FIFO_1R1W_COUNT_EN
  logic [lg_els_lp:0] r_count;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_count <= '0;
    else if (enq_o != deq_o) r_count <= enq_o ? r_count + 1'b1 : r_count - 1'b1;
  assign count_o = r_count;
  a_count_matches_tracker: assert property (@(posedge clk_i) disable iff (!reset_n_i || !r_init)
    ((r_count == '0) == empty_i) && ((r_count == (lg_els_lp+1)'(els_p)) == full_i));
`endif
endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_read.sv
// tb_bsg_fifo_1r1w_sync_read: table vectors plus scoreboard sequences against a behavioural tracker
module tb_bsg_fifo_1r1w_sync_read;
  localparam int W = 32;
  localparam int N = 256;
  localparam int LG = 8;
  typedef struct {
    logic v;
    logic y;
    logic [W-1:0] d;
    logic exp_ready;
    logic exp_v;
    logic [W-1:0] exp_data;
  } vec_t;
  logic clk_i = 1'b0, reset_n_i = 1'b0, v_i = 1'b0, yumi_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic ready_o, v_o, tracker_reset_o, enq_o, deq_o;
  logic [W-1:0] data_o;
  logic [LG-1:0] wptr_r = '0, rptr_r = '0, rptr_n;
  int t_cnt = 0;
  logic full, empty;
`ifdef BSG_FIFO_1R1W_COUNT_EN
  logic [LG:0] count_o;
`endif
  int vectors = 0, miscompares = 0;
  logic live = 1'b0;
  logic [W-1:0] sb[$];
  vec_t tbl[9];

  always #5 clk_i = ~clk_i;

  bsg_fifo_1r1w_sync_read #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .tracker_reset_o(tracker_reset_o), .enq_o(enq_o), .deq_o(deq_o),
    .wptr_r_i(wptr_r), .rptr_n_i(rptr_n), .full_i(full), .empty_i(empty)
`ifdef BSG_FIFO_1R1W_COUNT_EN
    , .count_o(count_o)
`endif
  );

  // behavioural bsg_fifo_tracker
  assign rptr_n = deq_o ? rptr_r + 1'b1 : rptr_r;
  assign full = (t_cnt == N);
  assign empty = (t_cnt == 0);
  always @(posedge clk_i)
    if (tracker_reset_o) begin
      wptr_r <= '0;
      rptr_r <= '0;
      t_cnt <= 0;
    end else begin
      wptr_r <= wptr_r + LG'(enq_o);
      rptr_r <= rptr_n;
      t_cnt <= t_cnt + int'(enq_o) - int'(deq_o);
    end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle's inputs just after a negedge and score the settled outputs
  task automatic cyc(input logic v, input logic y, input logic [W-1:0] d);
    v_i = v;
    data_i = d;
    yumi_i = y & v_o;
    #1;
    if (live) begin
      check("v_o", v_o, sb.size() != 0);
      check("ready_o", ready_o, sb.size() != N);
      check("enq_o", enq_o, v && (sb.size() != N));
      check("deq_o", deq_o, yumi_i);
`ifdef BSG_FIFO_1R1W_COUNT_EN
      check("count_o", count_o, sb.size());
`endif
    end
    if (yumi_i) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else check("head_data", data_o, sb.pop_front());
    end
    if (v_i && ready_o) sb.push_back(d);
  endtask

  task automatic tick(input logic v, input logic y, input logic [W-1:0] d);
    cyc(v, y, d);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    live = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_v", v_o, 0);
    check("rst_data", data_o, 0);
    check("rst_enq", enq_o, 0);
    check("rst_deq", deq_o, 0);
    check("rst_trk", tracker_reset_o, 1);
`ifdef BSG_FIFO_1R1W_COUNT_EN
    check("rst_count", count_o, 0);
`endif
    sb.delete();
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    v_i = 1'b1;
    #1;
    check("rel_ready", ready_o, 0);
    check("rel_enq", enq_o, 0);
    check("rel_trk", tracker_reset_o, 1);
    v_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("init_ready", ready_o, 1);
    check("init_v", v_o, 0);
    check("init_trk", tracker_reset_o, 0);
    live = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 32'h11,        1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 32'h22,        1'b1, 1'b1, 32'h11};
    tbl[5] = '{1'b1, 1'b1, 32'h33,        1'b1, 1'b1, 32'h22};
    tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h33};
    tbl[7] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h33};
    tbl[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].y, tbl[i].d);
      check($sformatf("tbl%0d_ready", i), ready_o, tbl[i].exp_ready);
      check($sformatf("tbl%0d_v", i), v_o, tbl[i].exp_v);
      if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
      @(negedge clk_i);
    end
    // fill to full, then v_i/yumi_i together while full, then drain
    for (int i = 0; i < N; i++) tick(1'b1, 1'b0, W'(i));
    check("full_ready", ready_o, 0);
    tick(1'b1, 1'b1, 32'h999);
    check("after_full_ready", ready_o, 1);
    tick(1'b1, 1'b0, 32'h1000);
    for (int k = 0; k < N + 8 && sb.size() != 0; k++) tick(1'b0, 1'b1, 32'h0);
    check("drain_left", sb.size(), 0);
    // streaming at occupancy 1 across many pointer wraps
    tick(1'b1, 1'b0, 32'h5000_0000);
    for (int i = 1; i <= 600; i++) tick(1'b1, 1'b1, 32'h5000_0000 + W'(i));
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick(1'b0, 1'b1, 32'h0);
    check("stream_left", sb.size(), 0);
    // reset with 10 entries queued
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h100 + W'(i));
    do_reset();
    tick(1'b1, 1'b0, 32'h7777_0007);
    tick(1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    check("post_rst_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
